// File: rtl/uimac_pause_sched.sv
// uimac_pause_sched: drains the show-ahead pause FIFO into per-class quanta timers; mask rises 2 edges after empty drops, max one entry per 3 clocks.
// Define UIMAC_PAUSE_ADDR_FILTER_EN to accept only entries addressed to 01-80-C2-00-00-01 or the local MAC.
module uimac_pause_sched #(
    parameter int NUM_CLASS     = 8,
    parameter int QUANTA_CYCLES = 64,
    parameter int QUANTA_W      = 16,
    parameter int CNT_W         = 16
) (
    input  logic                          I_gmii_tclk,
    input  logic                          I_mac_reset,
    input  logic [47:0]                   I_mac_local_addr,
    input  logic                          I_pause_empty,
    output logic                          O_pause_ren,
    input  logic [47:0]                   I_pause_addr,
    input  logic [NUM_CLASS-1:0]          I_pause_class_en,
    input  logic [NUM_CLASS*QUANTA_W-1:0] I_pause_quanta,
    output logic [NUM_CLASS-1:0]          O_class_pause,
    output logic                          O_pause_any,
    output logic [CNT_W-1:0]              O_accept_cnt,
    output logic [CNT_W-1:0]              O_drop_cnt
);

    localparam int               SUB_W      = $clog2(QUANTA_CYCLES);
    localparam logic [SUB_W-1:0] SUB_RELOAD = SUB_W'(QUANTA_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   capture_en, apply_en, entry_valid, load_en;

    logic [NUM_CLASS-1:0]          hold_en_q;
    logic [NUM_CLASS*QUANTA_W-1:0] hold_quanta_q;

    logic [QUANTA_W-1:0] qcnt_q [NUM_CLASS];
    logic [QUANTA_W-1:0] qcnt_d [NUM_CLASS];
    logic [SUB_W-1:0]    scnt_q [NUM_CLASS];
    logic [SUB_W-1:0]    scnt_d [NUM_CLASS];
    logic [NUM_CLASS-1:0] pause_q, pause_d;
    logic [CNT_W-1:0]     accept_q, accept_d, drop_q, drop_d;

    always_ff @(posedge I_gmii_tclk or posedge I_mac_reset) begin
        if (I_mac_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!I_pause_empty) state_d = ST_APPLY;
            ST_APPLY: state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The read pulse spans the APPLY cycle so the FIFO pops on the edge that consumes the entry.
    always_comb begin
        capture_en  = (state_q == ST_IDLE) && !I_pause_empty;
        apply_en    = (state_q == ST_APPLY);
        O_pause_ren = apply_en;
    end

`ifdef UIMAC_PAUSE_ADDR_FILTER_EN
    logic [47:0] hold_addr_q;

    always_ff @(posedge I_gmii_tclk or posedge I_mac_reset) begin
        if (I_mac_reset) begin
            hold_addr_q <= '0;
        end else if (capture_en) begin
            hold_addr_q <= I_pause_addr;
        end
    end

    assign entry_valid = (hold_addr_q == 48'h0180C2000001) || (hold_addr_q == I_mac_local_addr);
`else
    logic unused_addr;
    assign unused_addr = ^{I_pause_addr, I_mac_local_addr};
    assign entry_valid = 1'b1;
`endif

    assign load_en = apply_en && entry_valid;

    always_ff @(posedge I_gmii_tclk or posedge I_mac_reset) begin
        if (I_mac_reset) begin
            hold_en_q     <= '0;
            hold_quanta_q <= '0;
        end else if (capture_en) begin
            hold_en_q     <= I_pause_class_en;
            hold_quanta_q <= I_pause_quanta;
        end
    end

    // Load overrides countdown; a zero load clears the class at once (XON).
    always_comb begin
        for (int i = 0; i < NUM_CLASS; i++) begin
            qcnt_d[i] = qcnt_q[i];
            scnt_d[i] = scnt_q[i];
            if (qcnt_q[i] != '0) begin
                if (scnt_q[i] == '0) begin
                    qcnt_d[i] = qcnt_q[i] - QUANTA_W'(1);
                    scnt_d[i] = SUB_RELOAD;
                end else begin
                    scnt_d[i] = scnt_q[i] - SUB_W'(1);
                end
            end
            if (load_en && hold_en_q[i]) begin
                qcnt_d[i] = hold_quanta_q[i*QUANTA_W +: QUANTA_W];
                scnt_d[i] = SUB_RELOAD;
            end
            pause_d[i] = (qcnt_d[i] != '0);
        end
    end

    always_comb begin
        accept_d = accept_q;
        drop_d   = drop_q;
        if (load_en && (accept_q != '1)) accept_d = accept_q + CNT_W'(1);
        if (apply_en && !entry_valid && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
    end

    always_ff @(posedge I_gmii_tclk or posedge I_mac_reset) begin
        if (I_mac_reset) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                qcnt_q[i] <= '0;
                scnt_q[i] <= '0;
            end
            pause_q  <= '0;
            accept_q <= '0;
            drop_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                qcnt_q[i] <= qcnt_d[i];
                scnt_q[i] <= scnt_d[i];
            end
            pause_q  <= pause_d;
            accept_q <= accept_d;
            drop_q   <= drop_d;
        end
    end

    assign O_class_pause = pause_q;
    assign O_pause_any   = |pause_q;
    assign O_accept_cnt  = accept_q;
    assign O_drop_cnt    = drop_q;

endmodule

// File: tb/tb_uimac_pause_sched.sv
// Bench for uimac_pause_sched: FIFO plus timeline model predicting pause end times per class.
module tb_uimac_pause_sched;

    localparam int          NC         = 8;
    localparam int          QC         = 64;
    localparam int          QW         = 16;
    localparam int          CW         = 4;
    localparam logic [47:0] PAUSE_DA   = 48'h0180C2000001;
    localparam logic [47:0] LOCAL_ADDR = 48'h001122334455;
    localparam logic [47:0] OTHER_ADDR = 48'h112233445566;

    typedef struct {
        logic [47:0]      addr;
        logic [NC-1:0]    en;
        logic [NC*QW-1:0] quanta;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             empty = 1'b1;
    logic             ren;
    logic [47:0]      addr = '0;
    logic [NC-1:0]    cen = '0;
    logic [NC*QW-1:0] quanta = '0;
    logic [NC-1:0]    mask;
    logic             any;
    logic [CW-1:0]    acc_cnt, drop_cnt;

    uimac_pause_sched #(
        .NUM_CLASS    (NC),
        .QUANTA_CYCLES(QC),
        .QUANTA_W     (QW),
        .CNT_W        (CW)
    ) dut (
        .I_gmii_tclk     (clk),
        .I_mac_reset     (rst),
        .I_mac_local_addr(LOCAL_ADDR),
        .I_pause_empty   (empty),
        .O_pause_ren     (ren),
        .I_pause_addr    (addr),
        .I_pause_class_en(cen),
        .I_pause_quanta  (quanta),
        .O_class_pause   (mask),
        .O_pause_any     (any),
        .O_accept_cnt    (acc_cnt),
        .O_drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents, per-class pause deadline (in clock edges), counters.
    ent_t   fifo_q[$];
    ent_t   hold;
    longint edge_n = 0;
    longint until_e[NC];
    bit     pending = 0;
    bit     pop = 0;
    longint apply_edge = 0;
    longint next_cap = 0;
    int     m_acc = 0;
    int     m_drop = 0;
    int     vectors = 0;
    int     miscompares = 0;

    function automatic bit ent_valid(ent_t e);
`ifdef UIMAC_PAUSE_ADDR_FILTER_EN
        return (e.addr == PAUSE_DA) || (e.addr == LOCAL_ADDR);
`else
        return (e.addr == e.addr);
`endif
    endfunction

    function automatic logic [NC-1:0] exp_mask();
        logic [NC-1:0] m = '0;
        if (!rst)
            for (int i = 0; i < NC; i++) m[i] = (edge_n < until_e[i]);
        return m;
    endfunction

    function automatic logic exp_ren();
        return pending && !rst;
    endfunction

    function automatic logic [CW-1:0] exp_acc();
        return rst ? '0 : CW'(m_acc);
    endfunction

    function automatic logic [CW-1:0] exp_drop();
        return rst ? '0 : CW'(m_drop);
    endfunction

    function automatic ent_t mk(logic [47:0] a, logic [NC-1:0] en, int q);
        ent_t e;
        e.addr   = a;
        e.en     = en;
        e.quanta = '0;
        for (int i = 0; i < NC; i++)
            if (en[i]) e.quanta[i*QW +: QW] = QW'(q);
        return e;
    endfunction

    task automatic drive_fifo();
        empty = (fifo_q.size() == 0);
        if (!empty) begin
            addr   = fifo_q[0].addr;
            cen    = fifo_q[0].en;
            quanta = fifo_q[0].quanta;
        end
    endtask

    task automatic push(ent_t e);
        fifo_q.push_back(e);
        drive_fifo();
    endtask

    initial for (int i = 0; i < NC; i++) until_e[i] = 0;

    always begin
        @(posedge clk);
        edge_n++;
        if (rst) begin
            pending  = 0;
            next_cap = 0;
            m_acc    = 0;
            m_drop   = 0;
            for (int i = 0; i < NC; i++) until_e[i] = 0;
        end else if (pending && edge_n == apply_edge) begin
            pending = 0;
            pop     = 1;
            if (ent_valid(hold)) begin
                for (int i = 0; i < NC; i++)
                    if (hold.en[i]) until_e[i] = edge_n + longint'(hold.quanta[i*QW +: QW]) * QC;
                if (m_acc < (1 << CW) - 1) m_acc++;
            end else begin
                if (m_drop < (1 << CW) - 1) m_drop++;
            end
        end else if (!pending && edge_n >= next_cap && fifo_q.size() != 0) begin
            hold       = fifo_q[0];
            pending    = 1;
            apply_edge = edge_n + 1;
            next_cap   = edge_n + 3;
        end
        #1;
        if (pop) begin
            fifo_q.delete(0);
            pop = 0;
            drive_fifo();
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (mask !== '0 || any !== 1'b0 || ren !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs mask=%h any=%b ren=%b want 00/0/0", mask, any, ren);
        end
        vectors++;
        if (acc_cnt !== '0 || drop_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_counters acc=%0d drop=%0d want 0/0", acc_cnt, drop_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (mask !== '0 || ren !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release mask=%h ren=%b want 00/0", mask, ren);
        end
    endtask

    task automatic test_single();
        int hi = 0;
        int pulses = 0;
        push(mk(PAUSE_DA, 8'h01, 3));
        for (int c = 0; c < 210; c++) begin
            @(negedge clk);
            vectors++;
            if (mask !== exp_mask() || any !== (|exp_mask()) || ren !== exp_ren()) begin
                miscompares++;
                $display("FAIL single c=%0d mask=%h any=%b ren=%b want %h/%b/%b",
                         c, mask, any, ren, exp_mask(), |exp_mask(), exp_ren());
            end
            hi += int'(mask[0]);
            pulses += int'(ren);
        end
        vectors++;
        if (hi != 192 || pulses != 1) begin
            miscompares++;
            $display("FAIL single_len high=%0d pulses=%0d want 192/1", hi, pulses);
        end
        vectors++;
        if (acc_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL single_acc acc=%0d want 1", acc_cnt);
        end
    endtask

    task automatic test_xon();
        push(mk(PAUSE_DA, 8'h04, 10));
        for (int c = 0; c < 120; c++) begin
            if (c == 100) push(mk(PAUSE_DA, 8'h04, 0));
            @(negedge clk);
            vectors++;
            if (mask !== exp_mask() || ren !== exp_ren()) begin
                miscompares++;
                $display("FAIL xon c=%0d mask=%h ren=%b want %h/%b", c, mask, ren, exp_mask(), exp_ren());
            end
        end
        vectors++;
        if (mask !== 8'h00) begin
            miscompares++;
            $display("FAIL xon_end mask=%h want 00", mask);
        end
    endtask

    task automatic test_back_to_back();
        logic [NC-1:0] prev = '0;
        logic [NC-1:0] seq[$];
        longint        ren_e[$];
        logic [NC-1:0] want[6];
        want = '{8'h01, 8'h03, 8'h83, 8'h82, 8'h80, 8'h00};
        push(mk(PAUSE_DA, 8'h01, 5));
        push(mk(LOCAL_ADDR, 8'h02, 5));
        push(mk(PAUSE_DA, 8'h80, 5));
        for (int c = 0; c < 340; c++) begin
            @(negedge clk);
            vectors++;
            if (mask !== exp_mask() || ren !== exp_ren()) begin
                miscompares++;
                $display("FAIL b2b c=%0d mask=%h ren=%b want %h/%b", c, mask, ren, exp_mask(), exp_ren());
            end
            if (ren) ren_e.push_back(edge_n);
            if (mask !== prev) seq.push_back(mask);
            prev = mask;
        end
        vectors++;
        if (ren_e.size() != 3 || ren_e[1] - ren_e[0] != 3 || ren_e[2] - ren_e[1] != 3) begin
            miscompares++;
            $display("FAIL b2b_spacing pulses=%0d want 3 pulses 3 cycles apart", ren_e.size());
        end
        vectors++;
        if (seq.size() != 6) begin
            miscompares++;
            $display("FAIL b2b_seq_len got=%0d want 6", seq.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                vectors++;
                if (seq[k] !== want[k]) begin
                    miscompares++;
                    $display("FAIL b2b_seq k=%0d mask=%h want %h", k, seq[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_overwrite();
        int hi = 0;
        push(mk(PAUSE_DA, 8'h20, 60));
        for (int c = 0; c < 10 * QC + 3; c++) begin
            @(negedge clk);
            vectors++;
            if (mask !== exp_mask() || ren !== exp_ren()) begin
                miscompares++;
                $display("FAIL ovr_pre c=%0d mask=%h ren=%b want %h/%b", c, mask, ren, exp_mask(), exp_ren());
            end
        end
        push(mk(PAUSE_DA, 8'h20, 1));
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            vectors++;
            if (mask !== exp_mask() || ren !== exp_ren()) begin
                miscompares++;
                $display("FAIL ovr c=%0d mask=%h ren=%b want %h/%b", c, mask, ren, exp_mask(), exp_ren());
            end
            hi += int'(mask[5]);
        end
        vectors++;
        if (hi != QC + 1) begin
            miscompares++;
            $display("FAIL ovr_len high=%0d want %0d", hi, QC + 1);
        end
    endtask

    task automatic test_addr_filter();
        int hi = 0;
        int pulses = 0;
`ifdef UIMAC_PAUSE_ADDR_FILTER_EN
        int want_hi = 0;
        logic [CW-1:0] want_drop = 4'd1;
`else
        int want_hi = 4 * QC;
        logic [CW-1:0] want_drop = 4'd0;
`endif
        push(mk(OTHER_ADDR, 8'h10, 4));
        for (int c = 0; c < 4 * QC + 20; c++) begin
            @(negedge clk);
            vectors++;
            if (mask !== exp_mask() || ren !== exp_ren() || acc_cnt !== exp_acc() || drop_cnt !== exp_drop()) begin
                miscompares++;
                $display("FAIL filt c=%0d mask=%h ren=%b acc=%0d drop=%0d want %h/%b/%0d/%0d",
                         c, mask, ren, acc_cnt, drop_cnt, exp_mask(), exp_ren(), exp_acc(), exp_drop());
            end
            hi += int'(mask[4]);
            pulses += int'(ren);
        end
        vectors++;
        if (hi != want_hi || pulses != 1 || drop_cnt !== want_drop) begin
            miscompares++;
            $display("FAIL filt_sum high=%0d pulses=%0d drop=%0d want %0d/1/%0d", hi, pulses, drop_cnt, want_hi, want_drop);
        end
    endtask

    task automatic test_max_quanta();
        push(mk(LOCAL_ADDR, 8'h80, 16'hFFFF));
        for (int c = 0; c < 310; c++) begin
            if (c == 300) push(mk(PAUSE_DA, 8'h80, 0));
            @(negedge clk);
            vectors++;
            if (mask !== exp_mask() || ren !== exp_ren()) begin
                miscompares++;
                $display("FAIL maxq c=%0d mask=%h ren=%b want %h/%b", c, mask, ren, exp_mask(), exp_ren());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        push(mk(PAUSE_DA, 8'h01, 5));
        repeat (6) @(negedge clk);
        push(mk(PAUSE_DA, 8'h02, 2));
        push(mk(PAUSE_DA, 8'h04, 2));
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (pending && fifo_q.size() == 2) hit = 1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL rstmid_wait apply state not reached within 20 cycles");
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (mask !== '0 || any !== 1'b0 || ren !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_async mask=%h any=%b ren=%b want 00/0/0", mask, any, ren);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            vectors++;
            if (mask !== exp_mask() || ren !== exp_ren() || acc_cnt !== exp_acc()) begin
                miscompares++;
                $display("FAIL rstmid c=%0d mask=%h ren=%b acc=%0d want %h/%b/%0d",
                         c, mask, ren, acc_cnt, exp_mask(), exp_ren(), exp_acc());
            end
        end
        vectors++;
        if (acc_cnt !== 4'd2) begin
            miscompares++;
            $display("FAIL rstmid_acc acc=%0d want 2", acc_cnt);
        end
    endtask

    task automatic test_random();
        ent_t e;
        bit   done = 0;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       e.addr = PAUSE_DA;
                1:       e.addr = LOCAL_ADDR;
                default: e.addr = {16'h0A0B, 32'($urandom())};
            endcase
            e.en = NC'($urandom());
            for (int i = 0; i < NC; i++) e.quanta[i*QW +: QW] = QW'($urandom_range(0, 6));
            repeat ($urandom_range(0, 5)) begin
                @(negedge clk);
                vectors++;
                if (mask !== exp_mask() || any !== (|exp_mask()) || ren !== exp_ren() ||
                    acc_cnt !== exp_acc() || drop_cnt !== exp_drop()) begin
                    miscompares++;
                    $display("FAIL rand n=%0d mask=%h ren=%b acc=%0d drop=%0d want %h/%b/%0d/%0d",
                             n, mask, ren, acc_cnt, drop_cnt, exp_mask(), exp_ren(), exp_acc(), exp_drop());
                end
            end
            push(e);
        end
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            vectors++;
            if (mask !== exp_mask() || any !== (|exp_mask()) || ren !== exp_ren() ||
                acc_cnt !== exp_acc() || drop_cnt !== exp_drop()) begin
                miscompares++;
                $display("FAIL rand_drain c=%0d mask=%h ren=%b acc=%0d drop=%0d want %h/%b/%0d/%0d",
                         c, mask, ren, acc_cnt, drop_cnt, exp_mask(), exp_ren(), exp_acc(), exp_drop());
            end
            if (fifo_q.size() == 0 && !pending && exp_mask() == '0) done = 1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL rand_timeout fifo=%0d pending=%b", fifo_q.size(), pending);
        end
    endtask

    initial begin
        drive_fifo();
        test_reset();
        test_single();
        test_xon();
        test_back_to_back();
        test_overwrite();
        test_addr_filter();
        test_max_quanta();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
